tohost_reporter: RTL
====================

Name: tohost_reporter

Overview:
- Simulation and FPGA-side endpoint for the HTIF tohost/fromhost word protocol used by the core's test programs.
- Runtime configuration flows into the design through plusarg-style constants. This block carries status the other way, out of the design: exit codes, console characters and watchdog timeout.
- Sits between the core's tohost write channel and the testbench / UART bridge.
- Synthesizable. Optional simulation-only reporting.

Parameters:
- XLEN, 64: tohost/fromhost word width; must be ≥ 56.
- FIFO_DEPTH, 4: console character FIFO entries; power of two, ≥ 2.
- MAX_CYCLES, 0: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- tohost_valid  in  1  core presents a tohost word
- tohost_ready  out  1  block accepts the word
- tohost_data  in  XLEN  tohost word
- fromhost_valid  out  1  acknowledge word pending
- fromhost_ready  in  1  core consumes the acknowledge
- fromhost_data  out  XLEN  acknowledge word
- con_valid  out  1  console byte available
- con_ready  in  1  sink takes the byte
- con_data  out  8  console byte
- done  out  1  sticky: program exited or watchdog fired
- exit_code  out  XLEN-1  exit value; 0 = pass
- timeout  out  1  sticky: watchdog fired
- bad_cmd  out  1  sticky: unsupported command received

Behaviour:
- Reset is sampled on the clock edge when reset_n=0. All state clears:
  - state=IDLE, FIFO empty, cycle counter 0.
  - done, timeout, bad_cmd, fromhost_valid, con_valid = 0.
  - exit_code = 0, fromhost_data = 0.
  - A reset during ACK or DONE returns to IDLE the next cycle; FIFO contents are discarded.
- Field view of tohost_data: dev=[XLEN-1:XLEN-8], cmd=[XLEN-9:XLEN-16], payload=[XLEN-17:0].
- tohost_ready = (state==IDLE) && (fifo_count < FIFO_DEPTH).
- A word is accepted on a cycle where tohost_valid && tohost_ready.
- Decode of an accepted word, in priority order:
  1. Word == 0: no-op; stay IDLE.
  2. dev==0, cmd==0, bit0==1: exit. exit_code <= data[XLEN-1:1]; done <= 1; next state DONE.
  3. dev==1, cmd==1: console putc. Push data[7:0] into the FIFO. fromhost_data <= {8'd1, 8'd1, zeros}. Next state ACK.
  4. Anything else: bad_cmd <= 1; stay IDLE.
- State machine:
  - IDLE: accepts words as decoded above.
  - ACK: fromhost_valid=1 and tohost_ready=0. On fromhost_ready, go to IDLE next cycle; fromhost_valid falls in that same cycle.
  - DONE: terminal until reset. tohost_ready=0, fromhost_valid=0. The FIFO keeps draining.
- Console FIFO:
  - con_valid = !empty; con_data = head entry (registered FIFO, zero-latency head).
  - Pop on con_valid && con_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Push while full is impossible because ready gates it.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a putc is visible on con_valid the cycle after acceptance; fromhost_valid also rises the cycle after acceptance.
- Watchdog (MAX_CYCLES != 0):
  - 32-bit counter increments every cycle while !done.
  - When count == MAX_CYCLES-1: done <= 1, timeout <= 1, exit_code <= all ones, state <= DONE.
  - If a timeout and an accepted exit word occur in the same cycle, the exit word wins: timeout=0, the program's code is kept.
  - A timeout during ACK aborts the handshake; fromhost_valid drops.
  - The counter saturates once done is set.

Optional Feature:
- Macro: TOHOST_SIM_REPORT_EN. Effective only when SYNTHESIS is not defined.
- With the macro:
  - Each popped console byte is also written with $write("%c").
  - On the rising edge of done, $display prints "PASS", "FAIL code=<exit_code>" or "TIMEOUT".
  - $finish is called once the FIFO is empty after done.
- Without the macro: no system tasks. Port behaviour is identical either way.

Decomposition:
- Package tohost_pkg:
  - Constants HTIF_DEV_CONSOLE=8'd1, HTIF_CMD_PUTC=8'd1, HTIF_DEV_SYS=8'd0.
  - Enum state_e {IDLE, ACK, DONE}.
  - Function for the field-extraction helpers.
- Sub-module tohost_char_fifo: parameterized 8-bit synchronous FIFO with push/pop/full/empty/count.

Test Plan:
- Reset, then write 0x0000_0000_0000_0001 → next cycle done=1, exit_code=0, timeout=0, tohost_ready=0.
- Write 0x0101_0000_0000_0041 with con_ready=1, fromhost_ready=1 after 3 cycles → con_data=0x41 for 1 cycle; fromhost_valid high 3 cycles with fromhost_data=0x0101_0000_0000_0000; then IDLE.
- con_ready=0 with 4 putc words 'a'..'d' (FIFO_DEPTH=4):
  - tohost_ready=0 after the 4th.
  - Raise con_ready → bytes exit in order a,b,c,d; ready returns after the first pop.
- MAX_CYCLES=100 with no writes → done=1 and timeout=1 at cycle 100; exit_code=all ones. Exit word 0x15 presented on cycle 99 instead → exit_code=0xA, timeout=0.
- Write 0x0203_0000_0000_0000 → bad_cmd=1, state IDLE; a later exit word is still accepted.
- Assert reset_n=0 during ACK with 2 bytes queued → next cycle fromhost_valid=0, con_valid=0, done=0.

Source files
------------

// File: rtl/tohost_pkg.sv
// HTIF tohost/fromhost shared definitions: device/command codes, FSM states, field helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tohost_pkg;

    localparam logic [7:0] HTIF_DEV_SYS     = 8'd0;
    localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
    localparam logic [7:0] HTIF_CMD_EXIT    = 8'd0;
    localparam logic [7:0] HTIF_CMD_PUTC    = 8'd1;

    // Widest tohost word the helpers handle; narrower words are zero-extended into it.
    localparam int MAX_XLEN = 128;
    typedef logic [MAX_XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Device field: top byte of an xlen-wide word.
    function automatic logic [7:0] htif_dev(input word_t w, input int xlen);
        return w[xlen-1 -: 8];
    endfunction

    // Command field: second byte from the top.
    function automatic logic [7:0] htif_cmd(input word_t w, input int xlen);
        return w[xlen-9 -: 8];
    endfunction

    // Console character carried in the low byte of the payload.
    function automatic logic [7:0] htif_char(input word_t w);
        return w[7:0];
    endfunction

    // Acknowledge word for a console putc: dev/cmd echoed, payload zero.
    function automatic word_t htif_putc_ack(input int xlen);
        word_t w;
        w = '0;
        w[xlen-1 -: 8] = HTIF_DEV_CONSOLE;
        w[xlen-9 -: 8] = HTIF_CMD_PUTC;
        return w;
    endfunction

endpackage

// File: rtl/tohost_char_fifo.sv
// Console character FIFO: 8-bit entries, registered storage with the head visible combinationally.
// Latency: a pushed byte is at the head the cycle after the push when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; full/count let the writer stall.
module tohost_char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once the count covers them.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tohost_reporter.sv
// HTIF tohost endpoint: decodes exit/putc words, acks putc via fromhost, queues console bytes, runs a watchdog.
// Latency: accepted word -> done / fromhost_valid / con_valid one cycle later.
// Backpressure: tohost_ready low outside IDLE or with the console FIFO full; console drains on con_ready. Sim reporting: TOHOST_SIM_REPORT_EN.
module tohost_reporter
    import tohost_pkg::*;
#(
    parameter int XLEN       = 64,   // 56..MAX_XLEN
    parameter int FIFO_DEPTH = 4,    // power of two, >= 2
    parameter int MAX_CYCLES = 0     // 0 disables the watchdog
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tohost_valid,
    output logic              tohost_ready,
    input  logic [XLEN-1:0]   tohost_data,
    output logic              fromhost_valid,
    input  logic              fromhost_ready,
    output logic [XLEN-1:0]   fromhost_data,
    output logic              con_valid,
    input  logic              con_ready,
    output logic [7:0]        con_data,
    output logic              done,
    output logic [XLEN-2:0]   exit_code,
    output logic              timeout,
    output logic              bad_cmd
);

    localparam int    CW       = $clog2(FIFO_DEPTH) + 1;
    localparam word_t ACK_WORD = htif_putc_ack(XLEN);

    state_e          state;
    logic [31:0]     cyc;
    word_t           th_word;
    logic            accept;
    logic            is_zero;
    logic            is_exit;
    logic            is_putc;
    logic            exit_now;
    logic            wd_fire;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign th_word  = word_t'(tohost_data);
    assign is_zero  = (tohost_data == '0);
    assign is_exit  = (htif_dev(th_word, XLEN) == HTIF_DEV_SYS) &&
                      (htif_cmd(th_word, XLEN) == HTIF_CMD_EXIT) && tohost_data[0];
    assign is_putc  = (htif_dev(th_word, XLEN) == HTIF_DEV_CONSOLE) &&
                      (htif_cmd(th_word, XLEN) == HTIF_CMD_PUTC);

    assign tohost_ready = (state == IDLE) && (fifo_count < CW'(FIFO_DEPTH));
    assign accept       = tohost_valid && tohost_ready;
    assign exit_now     = accept && is_exit;

    // An exit takes priority over putc by decode order; the zero word is a no-op.
    assign push = accept && !is_zero && !is_exit && is_putc && !fifo_full;

    assign con_valid = !fifo_empty;
    assign pop       = con_valid && con_ready;

    // Fires on the cycle whose count is MAX_CYCLES-1, so done rises after exactly MAX_CYCLES cycles.
    assign wd_fire = (MAX_CYCLES != 0) && !done && (cyc == 32'(MAX_CYCLES - 1));

    tohost_char_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (htif_char(th_word)),
        .pop       (pop),
        .pop_data  (con_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Protocol FSM with registered status outputs; the watchdog overrides everything except a same-cycle exit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            cyc            <= '0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            bad_cmd        <= 1'b0;
            exit_code      <= '0;
            fromhost_valid <= 1'b0;
            fromhost_data  <= '0;
        end else begin
            if (!done) cyc <= cyc + 32'd1;

            case (state)
                IDLE: begin
                    if (accept && !is_zero) begin
                        if (is_exit) begin
                            exit_code <= tohost_data[XLEN-1:1];
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (is_putc) begin
                            fromhost_data  <= ACK_WORD[XLEN-1:0];
                            fromhost_valid <= 1'b1;
                            state          <= ACK;
                        end else begin
                            bad_cmd <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (fromhost_ready) begin
                        fromhost_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    // DONE is terminal until reset; the console FIFO keeps draining.
                end
            endcase

            if (wd_fire && !exit_now) begin
                done           <= 1'b1;
                timeout        <= 1'b1;
                exit_code      <= '1;
                fromhost_valid <= 1'b0;
                state          <= DONE;
            end
        end
    end

`ifndef SYNTHESIS
`ifdef TOHOST_SIM_REPORT_EN
    logic done_q;

    // Mirror console bytes and the final verdict to the simulator log, then end once the console drains.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
            if (pop) $write("%c", con_data);
            if (done && !done_q) begin
                if (timeout)               $display("TIMEOUT");
                else if (exit_code == '0)  $display("PASS");
                else                       $display("FAIL code=%0d", exit_code);
            end
            if (done && done_q && fifo_empty) $finish;
        end
    end
`endif
`endif

endmodule
